// File: rtl/lorenz_plot_reader.sv
`default_nettype none
// ============================================================================
//  Module      : lorenz_plot_reader
//  Description : Decimates the Lorenz x/y/z stream, projects two axes to pixel
//                coordinates and queues them for the VGA plotter. Optional
//                clamping of off-screen points: LORENZ_READER_CLAMP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lorenz_plot_reader #(
    parameter int DEPTH    = 16,
    parameter int PIX_W    = 10,
    parameter int SHIFT    = 18,
    parameter int OFFSET_A = 320,
    parameter int OFFSET_B = 240,
    parameter int MAX_A    = 639,
    parameter int MAX_B    = 479
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [26:0]              x,
    input  logic [26:0]              y,
    input  logic [26:0]              z,
    input  logic                     state_valid,
    output logic                     step_en,
    input  logic [15:0]              decim,
    input  logic [1:0]               proj_sel,
    output logic [PIX_W-1:0]         out_a,
    output logic [PIX_W-1:0]         out_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              overflow
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam logic signed [26:0]    c_off_a     = 27'(OFFSET_A);
    localparam logic signed [26:0]    c_off_b     = 27'(OFFSET_B);
    localparam logic signed [26:0]    c_max_a     = 27'(MAX_A);
    localparam logic signed [26:0]    c_max_b     = 27'(MAX_B);
    localparam logic [c_cnt_w-1:0]    c_full      = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w:0]      c_step_lim  = (c_cnt_w+1)'(DEPTH - 1);

    logic [15:0]              r_cnt;
    logic                     w_hit;
    logic signed [26:0]       w_sel_a, w_sel_b, w_p_a, w_p_b;
    logic [PIX_W-1:0]         w_pix_a, w_pix_b;
    logic                     w_keep;
    logic                     r_stage_valid;
    logic [PIX_W-1:0]         r_stage_a, r_stage_b;
    logic [2*PIX_W-1:0]       r_mem [DEPTH];
    logic [c_cnt_w-1:0]       r_wr_ptr, r_rd_ptr, w_count;
    logic                     w_full, w_push, w_pop;
    logic [c_cnt_w:0]         w_occ;
    logic [15:0]              r_overflow;
    logic                     r_step_en;
    logic [2*PIX_W-1:0]       w_head;

    assign w_hit = state_valid && (r_cnt >= decim);

    always_comb begin
        w_sel_a = $signed(x);
        w_sel_b = $signed(y);
        case (proj_sel)
            2'd1:    begin w_sel_a = $signed(y); w_sel_b = $signed(z); end
            2'd2:    begin w_sel_a = $signed(x); w_sel_b = $signed(z); end
            default: begin w_sel_a = $signed(x); w_sel_b = $signed(y); end
        endcase
    end

    assign w_p_a = (w_sel_a >>> SHIFT) + c_off_a;
    assign w_p_b = (w_sel_b >>> SHIFT) + c_off_b;

`ifdef LORENZ_READER_CLAMP_EN
    always_comb begin
        w_keep  = 1'b1;
        w_pix_a = w_p_a[26] ? '0 : (w_p_a > c_max_a) ? c_max_a[PIX_W-1:0] : w_p_a[PIX_W-1:0];
        w_pix_b = w_p_b[26] ? '0 : (w_p_b > c_max_b) ? c_max_b[PIX_W-1:0] : w_p_b[PIX_W-1:0];
    end
`else
    always_comb begin
        w_keep  = !w_p_a[26] && (w_p_a <= c_max_a) && !w_p_b[26] && (w_p_b <= c_max_b);
        w_pix_a = w_p_a[PIX_W-1:0];
        w_pix_b = w_p_b[PIX_W-1:0];
    end
`endif

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == c_full);
    assign w_pop   = out_valid && out_ready;
    // Fullness is judged before the pop, so a full FIFO refuses the push even while draining.
    assign w_push  = r_stage_valid && !w_full;
    assign w_occ   = {1'b0, w_count} + (c_cnt_w+1)'(r_stage_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_stage_valid <= 1'b0;
            r_stage_a     <= '0;
            r_stage_b     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_overflow    <= '0;
            r_step_en     <= 1'b0;
        end else begin
            if (state_valid)
                r_cnt <= w_hit ? 16'd0 : r_cnt + 16'd1;
            r_stage_valid <= w_hit && w_keep;
            if (w_hit) begin
                r_stage_a <= w_pix_a;
                r_stage_b <= w_pix_b;
            end
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_stage_valid && w_full && (r_overflow != 16'hFFFF))
                r_overflow <= r_overflow + 16'd1;
            r_step_en <= (w_occ < c_step_lim);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= {r_stage_a, r_stage_b};
    end

    // Head is forced to zero when empty so outputs read 0 throughout reset.
    assign w_head     = out_valid ? r_mem[r_rd_ptr[c_addr_w-1:0]] : '0;
    assign out_valid  = (w_count != '0);
    assign out_a      = w_head[2*PIX_W-1:PIX_W];
    assign out_b      = w_head[PIX_W-1:0];
    assign fifo_count = w_count;
    assign overflow   = r_overflow;
    assign step_en    = r_step_en;

endmodule
`default_nettype wire

// File: tb/tb_lorenz_plot_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lorenz_plot_reader
//  Description : Directed self-checking bench for lorenz_plot_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lorenz_plot_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] x, y, z;
    logic        state_valid;
    logic        step_en;
    logic [15:0] decim;
    logic [1:0]  proj_sel;
    logic [9:0]  out_a, out_b;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fifo_count;
    logic [15:0] overflow;

    int errors = 0;
    int checks = 0;

    lorenz_plot_reader dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .z           (z),
        .state_valid (state_valid),
        .step_en     (step_en),
        .decim       (decim),
        .proj_sel    (proj_sel),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int  stop_i;
        bit  stopped;
        reset = 1'b0; x = '0; y = '0; z = '0; state_valid = 1'b0;
        decim = '0; proj_sel = '0; out_ready = 1'b0;
        cyc(2);
        chk("rst_valid",    32'(out_valid),  0);
        chk("rst_count",    32'(fifo_count), 0);
        chk("rst_stepen",   32'(step_en),    0);
        chk("rst_overflow", 32'(overflow),   0);
        chk("rst_out_a",    32'(out_a),      0);
        reset = 1'b1;
        cyc(1);
        chk("rel_stepen", 32'(step_en), 1);

        // Projection (x,z): 25.0 -> 420, -10.0 -> 200
        proj_sel = 2'd2; x = 27'h1900000; z = 27'h7600000; state_valid = 1'b1;
        cyc(1);
        state_valid = 1'b0;
        chk("proj_valid_t1", 32'(out_valid), 0);
        cyc(1);
        chk("proj_valid_t2", 32'(out_valid), 1);
        chk("proj_a",        32'(out_a),     420);
        chk("proj_b",        32'(out_b),     200);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("proj_drain", 32'(fifo_count), 0);

        // Decimation by 4: step k carries x=k.0 -> A = 320 + 4k
        decim = 16'd3; proj_sel = 2'd0; y = '0; z = '0;
        for (int k = 1; k <= 12; k++) begin
            x = 27'(k << 20); state_valid = 1'b1;
            cyc(1);
        end
        state_valid = 1'b0;
        cyc(2);
        chk("dec_count", 32'(fifo_count), 3);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            chk("dec_head_a", 32'(out_a), 32'(320 + 16 * k));
            chk("dec_head_b", 32'(out_b), 240);
            cyc(1);
        end
        out_ready = 1'b0;
        chk("dec_empty", 32'(fifo_count), 0);

        // Backpressure: integrator obeys step_en until it drops
        decim = 16'd0; stopped = 1'b0; stop_i = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stopped) begin
                if (!step_en) begin
                    stopped = 1'b1;
                    stop_i  = i;
                end else begin
                    x = 27'(i << 20); state_valid = 1'b1;
                    cyc(1);
                end
            end
        end
        state_valid = 1'b0;
        chk("bp_stepen_dropped", 32'(stopped),    1);
        chk("bp_stop_step",      32'(stop_i),     16);
        chk("bp_count_at_drop",  32'(fifo_count), 15);
        for (int i = 16; i <= 18; i++) begin
            x = 27'(i << 20); state_valid = 1'b1;
            cyc(1);
        end
        state_valid = 1'b0;
        cyc(2);
        chk("bp_count_full", 32'(fifo_count), 16);
        chk("bp_overflow",   32'(overflow),   3);
        chk("bp_head_a",     32'(out_a),      320);
        chk("bp_stepen_low", 32'(step_en),    0);

        // Full FIFO with a valid stage and a simultaneous pop
        x = 27'(20 << 20); state_valid = 1'b1;
        cyc(1);
        state_valid = 1'b0; out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("fp_count",    32'(fifo_count), 15);
        chk("fp_overflow", 32'(overflow),   4);
        chk("fp_head_a",   32'(out_a),      324);
        x = 27'(21 << 20); state_valid = 1'b1;
        cyc(1);
        state_valid = 1'b0;
        cyc(1);
        chk("fp_push_ok",  32'(fifo_count), 16);
        chk("fp_ovf_same", 32'(overflow),   4);
        out_ready = 1'b1;
        cyc(16);
        out_ready = 1'b0;
        chk("fp_drained", 32'(fifo_count), 0);

        // Off-screen B: y=62.0 -> 488 > 479, y=-63.0 -> -12 < 0
        x = 27'h1900000; y = 27'h3E00000; state_valid = 1'b1;
        cyc(1);
        y = 27'h4100000;
        cyc(1);
        state_valid = 1'b0;
        cyc(2);
        chk("clamp_ovf", 32'(overflow), 4);
`ifdef LORENZ_READER_CLAMP_EN
        chk("clamp_count", 32'(fifo_count), 2);
        chk("clamp_hi_a",  32'(out_a),      420);
        chk("clamp_hi_b",  32'(out_b),      479);
        out_ready = 1'b1;
        cyc(1);
        chk("clamp_lo_b",  32'(out_b),      0);
        cyc(1);
        out_ready = 1'b0;
`else
        chk("clamp_count", 32'(fifo_count), 0);
`endif

        // Asynchronous reset with five entries queued
        x = '0; y = '0; state_valid = 1'b1;
        cyc(5);
        state_valid = 1'b0;
        cyc(2);
        chk("ar_count_before", 32'(fifo_count), 5);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid",    32'(out_valid),  0);
        chk("ar_count",    32'(fifo_count), 0);
        chk("ar_stepen",   32'(step_en),    0);
        chk("ar_overflow", 32'(overflow),   0);
        chk("ar_out_b",    32'(out_b),      0);
        cyc(1);
        reset = 1'b1;
        chk("ar_stepen_rel", 32'(step_en), 0);
        cyc(1);
        chk("ar_stepen_next", 32'(step_en), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
